cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares one common data bus (CDB) between N_REQ functional-unit result producers: ALU, branch unit and load/store buffer.
- Each requester owns a one-entry holding buffer. A round-robin arbiter picks one buffered result per cycle and drives it as a registered broadcast.
- The broadcast goes to reservation stations, the load/store buffer and the ROB.
- The block guarantees a bounded broadcast latency and no lost results.

Parameters:
- N_REQ, 3, number of requesting units. Index 0 = ALU, 1 = branch, 2 = load/store.
- DATA_W, 32, result data width.
- ROB_W, 4, ROB tag width. Tag value 0 (ZERO_ROB) means "no destination".

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-low.
- in_clear  input  1  synchronous flush on branch mispredict, active-high.
- in_valid  input  N_REQ  per-requester result valid.
- in_ready  output  N_REQ  per-requester accept. A transfer occurs when in_valid[i] & in_ready[i] at a rising edge.
- in_rob_tag  input  N_REQ*ROB_W  packed tags; requester i occupies bits [i*ROB_W +: ROB_W].
- in_data  input  N_REQ*DATA_W  packed results, same packing as in_rob_tag.
- out_cdb_valid  output  1  broadcast valid.
- out_cdb_rob_tag  output  ROB_W  broadcast tag.
- out_cdb_data  output  DATA_W  broadcast data.
- out_cdb_src  output  clog2(N_REQ)  index of the requester being broadcast.

Behaviour:
- Reset (rst low, asynchronous, at any time including mid-operation):
  - all buf_valid cleared, rr_ptr = 0;
  - out_cdb_valid = 0, out_cdb_rob_tag = 0, out_cdb_data = 0, out_cdb_src = 0.
  - The first capture occurs on the first rising edge after rst is released high.
- Per-requester state: buf_valid[i], buf_tag[i], buf_data[i].
- in_ready[i] = ~buf_valid[i] | grant[i]. It is combinational, so a requester granted this cycle can refill in the same cycle.
- Accept: on in_valid[i] & in_ready[i] & ~in_clear with in_rob_tag[i] != 0, the buffer captures tag and data and buf_valid[i] <= 1.
  - With in_rob_tag[i] == 0 the handshake still completes, but the result is discarded and never broadcast.
- Arbitration (combinational):
  - Candidates are buffers with buf_valid set.
  - Search starts at rr_ptr and wraps modulo N_REQ; the first candidate found wins, giving one-hot grant.
  - The search never considers incoming in_valid directly.
- Broadcast (registered) when a winner w exists:
  - out_cdb_valid <= 1, out_cdb_rob_tag <= buf_tag[w], out_cdb_data <= buf_data[w], out_cdb_src <= w;
  - buf_valid[w] <= 0 unless refilled the same edge;
  - rr_ptr <= (w+1) mod N_REQ.
- When no winner exists: out_cdb_valid <= 0, out_cdb_rob_tag <= 0 and out_cdb_data <= 0, so consumers comparing against tag 0 never match. rr_ptr holds.
- Latency: a result accepted at edge t is broadcast, at the earliest, in the cycle following edge t+1.
- Starvation bound: a buffered result is broadcast within N_REQ cycles of being buffered.
- Throughput:
  - one broadcast per cycle overall;
  - a sole active requester sustains one result per cycle.
- Same-edge grant and refill on requester i: the new data replaces the old buffer entry and buf_valid stays 1. The old entry is the one broadcast.
- in_clear high at an edge:
  - all buf_valid <= 0, rr_ptr <= 0, out_cdb_valid <= 0, tag <= 0;
  - no capture and no broadcast occur at that edge;
  - in_ready still follows the formula above. Handshakes that complete during clear are dropped.
- in_clear takes priority over accept and grant. rst takes priority over everything.
- Outputs change only on clock edges or reset.

Test Plan:
1. Single ALU result (tag 5, data 0x0000_00AA) accepted at edge 1 -> out_cdb_valid = 1, tag 5, data 0xAA, src 0 after edge 2; valid = 0 after edge 3.
2. All three requesters valid at edge 1 (tags 1, 2, 3), rr_ptr = 0 -> broadcasts tag 1, 2, 3 (src 0, 1, 2) in consecutive cycles; in_ready for 1 and 2 stays low until each is granted.
3. ALU streams tags 1..8 back-to-back while the other units are idle -> 8 consecutive broadcasts with no bubble and in_ready[0] constantly 1. With branch continuously valid as well, the two requesters alternate src 0 and 1.
4. Load/store presents tag 0, data 0x1234 -> handshake completes and nothing is broadcast (out_cdb_valid stays 0).
5. Three entries buffered and in_clear pulsed for one cycle after the first broadcast -> no further broadcasts, rr_ptr = 0, and a next fresh result is broadcast normally with src equal to its requester.
6. rst driven low asynchronously between edges with buffers full and out_cdb_valid = 1 -> outputs go to 0 immediately without a clock edge; after release, no stale tag is ever broadcast.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per result producer, round-robin
// selection among buffered results, and a registered broadcast of the winner.
module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_clear,
  input  logic [N_REQ-1:0]          in_valid,
  output logic [N_REQ-1:0]          in_ready,
  input  logic [N_REQ*ROB_W-1:0]    in_rob_tag,
  input  logic [N_REQ*DATA_W-1:0]   in_data,
  output logic                      out_cdb_valid,
  output logic [ROB_W-1:0]          out_cdb_rob_tag,
  output logic [DATA_W-1:0]         out_cdb_data,
  output logic [SRC_W-1:0]          out_cdb_src
);

  logic [N_REQ-1:0]  buf_valid;
  logic [ROB_W-1:0]  buf_tag  [N_REQ];
  logic [DATA_W-1:0] buf_data [N_REQ];
  logic [SRC_W-1:0]  rr_ptr;

  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  accept;
  logic [SRC_W-1:0]  win;
  logic [SRC_W-1:0]  idx;
  logic              found;

  // Only buffered entries compete; incoming results never bypass their buffer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    grant = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = SRC_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && buf_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) grant[win] = 1'b1;
  end

  assign in_ready = ~buf_valid | grant;

  // A tag of zero completes the handshake but is never stored.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_REQ; i++)
      accept[i] = in_valid[i] && in_ready[i] && !in_clear &&
                  (in_rob_tag[i*ROB_W +: ROB_W] != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid       <= '0;
      rr_ptr          <= '0;
      out_cdb_valid   <= 1'b0;
      out_cdb_rob_tag <= '0;
      out_cdb_data    <= '0;
      out_cdb_src     <= '0;
    end else if (in_clear) begin
      buf_valid       <= '0;
      rr_ptr          <= '0;
      out_cdb_valid   <= 1'b0;
      out_cdb_rob_tag <= '0;
      out_cdb_data    <= '0;
    end else begin
      // Refill after release so a same-edge grant and capture keeps the entry valid.
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i])  buf_valid[i] <= 1'b0;
        if (accept[i]) buf_valid[i] <= 1'b1;
      end
      if (found) begin
        out_cdb_valid   <= 1'b1;
        out_cdb_rob_tag <= buf_tag[win];
        out_cdb_data    <= buf_data[win];
        out_cdb_src     <= win;
        rr_ptr          <= (win == SRC_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end else begin
        out_cdb_valid   <= 1'b0;
        out_cdb_rob_tag <= '0;
        out_cdb_data    <= '0;
      end
    end
  end

  // NOTE: payload storage has no reset; buf_valid alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        buf_tag[i]  <= in_rob_tag[i*ROB_W +: ROB_W];
        buf_data[i] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus queues the expected broadcasts,
// a negedge monitor pops and compares each one the DUT presents.
module tb_cdb_arbiter;
  localparam int N_REQ  = 3;
  localparam int DATA_W = 32;
  localparam int ROB_W  = 4;
  localparam int SRC_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_clear;
  logic [N_REQ-1:0]        in_valid;
  logic [N_REQ-1:0]        in_ready;
  logic [N_REQ*ROB_W-1:0]  in_rob_tag;
  logic [N_REQ*DATA_W-1:0] in_data;
  logic                    out_cdb_valid;
  logic [ROB_W-1:0]        out_cdb_rob_tag;
  logic [DATA_W-1:0]       out_cdb_data;
  logic [SRC_W-1:0]        out_cdb_src;

  cdb_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .in_clear(in_clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rob_tag(in_rob_tag), .in_data(in_data),
    .out_cdb_valid(out_cdb_valid), .out_cdb_rob_tag(out_cdb_rob_tag),
    .out_cdb_data(out_cdb_data), .out_cdb_src(out_cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ROB_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } bcast_t;

  bcast_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_bcast(input int tag, input int data, input int src);
    bcast_t e;
    e.tag  = ROB_W'(tag);
    e.data = DATA_W'(data);
    e.src  = SRC_W'(src);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input int tag, input int data);
    in_valid[i]                 = v;
    in_rob_tag[i*ROB_W +: ROB_W] = ROB_W'(tag);
    in_data[i*DATA_W +: DATA_W]  = DATA_W'(data);
  endtask

  task automatic idle_inputs();
    in_valid   = '0;
    in_rob_tag = '0;
    in_data    = '0;
  endtask

  // Monitor: every presented broadcast must match the head of the scoreboard.
  initial begin
    bcast_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && out_cdb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("cdb_unexpected_valid", 64'(out_cdb_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("cdb_tag",  64'(out_cdb_rob_tag), 64'(e.tag));
          check("cdb_data", 64'(out_cdb_data),    64'(e.data));
          check("cdb_src",  64'(out_cdb_src),     64'(e.src));
        end
      end
    end
  end

  initial begin
    int a_cnt, b_cnt, budget;
    logic [N_REQ-1:0] rdy, vld;

    rst = 1'b0;
    in_clear = 1'b0;
    idle_inputs();
    #12;
    check("reset_valid", 64'(out_cdb_valid), 64'd0);
    check("reset_tag",   64'(out_cdb_rob_tag), 64'd0);
    check("reset_data",  64'(out_cdb_data), 64'd0);
    check("reset_src",   64'(out_cdb_src), 64'd0);
    check("reset_ready", 64'(in_ready), 64'b111);
    @(negedge clk);
    rst = 1'b1;

    // 1: single ALU result
    step();
    set_req(0, 1'b1, 5, 32'hAA);
    expect_bcast(5, 32'hAA, 0);
    step();
    idle_inputs();
    check("t1_no_bypass", 64'(out_cdb_valid), 64'd0);
    step();
    check("t1_valid_after_edge2", 64'(out_cdb_valid), 64'd1);
    step();
    check("t1_idle_after_edge3", 64'(out_cdb_valid), 64'd0);

    // 2: all three at once from rr_ptr = 0
    in_clear = 1'b1;
    step();
    in_clear = 1'b0;
    set_req(0, 1'b1, 1, 32'h11);
    set_req(1, 1'b1, 2, 32'h22);
    set_req(2, 1'b1, 3, 32'h33);
    expect_bcast(1, 32'h11, 0);
    expect_bcast(2, 32'h22, 1);
    expect_bcast(3, 32'h33, 2);
    step();
    idle_inputs();
    check("t2_ready_e1", 64'(in_ready), 64'b001);
    step();
    check("t2_ready_e2", 64'(in_ready), 64'b011);
    step();
    check("t2_ready_e3", 64'(in_ready), 64'b111);
    step();
    step();
    check("t2_drained", 64'(out_cdb_valid), 64'd0);

    // 3a: ALU streams tags 1..8 with no bubble
    for (int i = 1; i <= 8; i++) begin
      set_req(0, 1'b1, i, 32'h100 + i);
      expect_bcast(i, 32'h100 + i, 0);
      check("t3_alu_ready", 64'(in_ready[0]), 64'd1);
      if (i >= 3) check("t3_no_bubble", 64'(out_cdb_valid), 64'd1);
      step();
    end
    idle_inputs();
    check("t3_tail7", 64'(out_cdb_valid), 64'd1);
    step();
    check("t3_tail8", 64'(out_cdb_valid), 64'd1);
    step();
    check("t3_stream_end", 64'(out_cdb_valid), 64'd0);

    // 3b: ALU and branch both busy from rr_ptr = 1 -> branch, ALU alternate
    for (int k = 0; k < 4; k++) begin
      expect_bcast(5 + k, 32'hB00 + k, 1);
      expect_bcast(1 + k, 32'hA00 + k, 0);
    end
    a_cnt = 0; b_cnt = 0; budget = 0;
    while ((a_cnt < 4 || b_cnt < 4) && budget < 40) begin
      vld = {1'b0, (b_cnt < 4), (a_cnt < 4)};
      set_req(0, vld[0], 1 + a_cnt, 32'hA00 + a_cnt);
      set_req(1, vld[1], 5 + b_cnt, 32'hB00 + b_cnt);
      rdy = in_ready;
      step();
      if (vld[0] && rdy[0]) a_cnt++;
      if (vld[1] && rdy[1]) b_cnt++;
      budget++;
    end
    idle_inputs();
    check("t3b_handshake_budget", 64'(budget < 40), 64'd1);
    repeat (4) step();
    check("t3b_scoreboard_drained", 64'(sb.size()), 64'd0);

    // 4: zero tag is swallowed
    set_req(2, 1'b1, 0, 32'h1234);
    check("t4_ls_ready", 64'(in_ready[2]), 64'd1);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check("t4_no_bcast", 64'(out_cdb_valid), 64'd0);
      step();
    end

    // 5: clear after first broadcast (rr_ptr = 1 here, branch wins first)
    set_req(0, 1'b1, 1, 32'h51);
    set_req(1, 1'b1, 2, 32'h52);
    set_req(2, 1'b1, 3, 32'h53);
    expect_bcast(2, 32'h52, 1);
    step();
    idle_inputs();
    step();
    check("t5_first_bcast", 64'(out_cdb_valid), 64'd1);
    in_clear = 1'b1;
    step();
    in_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_flushed", 64'(out_cdb_valid), 64'd0);
      check("t5_flushed_tag", 64'(out_cdb_rob_tag), 64'd0);
      step();
    end
    // rr_ptr back at 0: branch beats load/store
    set_req(1, 1'b1, 6, 32'h66);
    set_req(2, 1'b1, 7, 32'h77);
    expect_bcast(6, 32'h66, 1);
    expect_bcast(7, 32'h77, 2);
    step();
    idle_inputs();
    repeat (3) step();
    check("t5_fresh_drained", 64'(sb.size()), 64'd0);

    // 6: asynchronous reset mid-operation (rr_ptr = 0 here)
    set_req(0, 1'b1, 1, 32'h61);
    set_req(1, 1'b1, 2, 32'h62);
    set_req(2, 1'b1, 3, 32'h63);
    expect_bcast(1, 32'h61, 0);
    step();
    idle_inputs();
    step();
    check("t6_pre_reset_valid", 64'(out_cdb_valid), 64'd1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t6_async_valid", 64'(out_cdb_valid), 64'd0);
    check("t6_async_tag",   64'(out_cdb_rob_tag), 64'd0);
    check("t6_async_data",  64'(out_cdb_data), 64'd0);
    check("t6_async_ready", 64'(in_ready), 64'b111);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_no_stale", 64'(out_cdb_valid), 64'd0);
    end
    set_req(0, 1'b1, 9, 32'h99);
    expect_bcast(9, 32'h99, 0);
    step();
    idle_inputs();
    step();
    check("t6_resume", 64'(out_cdb_valid), 64'd1);
    step();

    check("final_scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
